// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU instruction-fetch and data accesses onto one
// single-port memory through a req/ack handshake. Each granted access has a
// watchdog that aborts it with an error ack after TIMEOUT cycles without m_ack.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration on contention;
// when it is undefined, data always beats fetch.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_type,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        err_sticky,
  output logic        stall,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_type,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 0 = fetch, 1 = data
  logic [15:0] cnt_q, cnt_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;
  logic        err_sticky_q, err_sticky_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [2:0]  m_type_q, m_type_d;

  logic        if_cand, d_cand, prefer_d, grant_d, tmo_hit, done, abort;

  // Requester-side stall: anything asked for and not yet acknowledged.
  assign stall = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

  // Next-state logic: grant in IDLE, completion or watchdog abort in BUSY.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_type_d     = m_type_q;

    // A requester whose ack is high this cycle still shows its old request.
    if_cand = if_req & ~if_ack_q;
    d_cand  = d_req & ~d_ack_q;
`ifdef MEM_ARB_RR_EN
    prefer_d = ~last_grant_q;
`else
    prefer_d = 1'b1;
`endif
    grant_d = d_cand & (~if_cand | prefer_d);

    // The current BUSY cycle is number cnt_q+1; 32-bit compare avoids wrap.
    tmo_hit = ({16'd0, cnt_q} + 32'd1) >= TIMEOUT;
    done    = m_ack | tmo_hit;
    abort   = ~m_ack & tmo_hit;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d      = BUSY_D;
          last_grant_d = 1'b1;
          cnt_d        = '0;
          m_req_d      = 1'b1;
          m_we_d       = d_we;
          m_addr_d     = d_addr;
          m_wdata_d    = d_wdata;
          m_type_d     = d_type;
        end else if (if_cand) begin
          state_d      = BUSY_IF;
          last_grant_d = 1'b0;
          cnt_d        = '0;
          m_req_d      = 1'b1;
          m_we_d       = 1'b0;
          m_addr_d     = if_addr;
          m_wdata_d    = '0;
          m_type_d     = '0;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (done) begin
          state_d      = IDLE;
          m_req_d      = 1'b0;
          err_d        = abort;
          err_sticky_d = err_sticky_q | abort;
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = abort ? '0 : m_rdata;
          end else begin
            d_ack_d    = 1'b1;
            d_rdata_d  = (abort | m_we_q) ? '0 : m_rdata;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_type_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_type_q     <= m_type_d;
    end
  end

  assign if_ack     = if_ack_q;
  assign d_ack      = d_ack_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
  assign m_type     = m_type_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level bench for mem_arbiter. The bench plays
// both CPU requesters and the memory, predicts grant order, ack timing, data
// and error flags from the arbitration rules, and compares every cycle.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_type = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err, err_sticky, stall;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_type;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: last observed-by-model data values and grant history.
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  logic        exp_sticky = 1'b0;
  int          lg = 1;  // 1 = fetch, 2 = data

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_type(d_type), .d_ack(d_ack), .d_rdata(d_rdata),
    .err(err), .err_sticky(err_sticky), .stall(stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_type(m_type), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish by 2ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_acks"}, {if_ack, d_ack, err, err_sticky, m_req, m_we}, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_wdata"}, m_wdata, 0);
    check({tag, "_m_type"}, m_type, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  // Winner when both requesters contend.
  function automatic int contention_winner();
`ifdef MEM_ARB_RR_EN
    return (lg == 1) ? 2 : 1;
`else
    return 2;
`endif
  endfunction

  // Called right after the grant edge; plays the memory with the given
  // latency (m_ack in BUSY cycle 'lat', counting from 0) and checks the ack.
  task automatic serve(input int who, input logic [31:0] ea, input logic ewe,
                       input logic [31:0] ewd, input logic [2:0] ety,
                       input int lat, input logic [31:0] rd);
    int  k;
    bit  done, to;
    logic s;
    k = 0; done = 0; to = 0;
    lg = who;
    while (!done) begin
      check("m_req_busy", m_req, 1);
      check("m_addr", m_addr, ea);
      check("m_we", m_we, ewe);
      check("m_wdata", m_wdata, ewd);
      check("m_type", m_type, ety);
      check("acks_busy", {if_ack, d_ack, err}, 0);
      check("stall_busy", stall, 1);
      m_ack   = (k == lat);
      m_rdata = (k == lat) ? rd : $urandom();
      @(posedge clk); #1;
      if (k == lat) done = 1;
      else if (k == TO - 1) begin done = 1; to = 1; end
      k++;
    end
    m_ack = 1'b0;
    if (to) exp_sticky = 1'b1;
    if (who == 1) exp_if_rdata = to ? 32'd0 : rd;
    else          exp_d_rdata  = (to || ewe) ? 32'd0 : rd;
    check("if_ack_done", if_ack, who == 1);
    check("d_ack_done", d_ack, who == 2);
    check("err_done", err, to);
    check("err_sticky", err_sticky, exp_sticky);
    check("m_req_done", m_req, 0);
    check("if_rdata", if_rdata, exp_if_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);
    s = (who == 1) ? d_req : if_req;
    check("stall_at_ack", stall, s);
  endtask

  // One idle cycle with no requests; a stray m_ack must be ignored.
  task automatic idle_cycle();
    m_ack   = $urandom_range(0, 1);
    m_rdata = $urandom();
    @(posedge clk); #1;
    m_ack = 1'b0;
    check("idle_acks", {if_ack, d_ack, err, m_req}, 0);
    check("idle_stall", stall, 0);
  endtask

  task automatic run_txn(input bit do_if, input logic [31:0] ia,
                         input bit do_d, input logic dwe, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [2:0] dty,
                         input int lat_if, input logic [31:0] rd_if,
                         input int lat_d, input logic [31:0] rd_d);
    int first;
    if_req = do_if; if_addr = ia;
    d_req = do_d; d_we = dwe; d_addr = da; d_wdata = dwd; d_type = dty;
    #1;
    check("stall_req", stall, do_if | do_d);
    @(posedge clk); #1;
    if (do_if && do_d) first = contention_winner();
    else first = do_d ? 2 : 1;
    if (first == 2) begin
      serve(2, da, dwe, dwd, dty, lat_d, rd_d);
      d_req = 1'b0;
      if (do_if) begin
        @(posedge clk); #1;
        serve(1, ia, 1'b0, 32'd0, 3'd0, lat_if, rd_if);
        if_req = 1'b0;
      end
    end else begin
      serve(1, ia, 1'b0, 32'd0, 3'd0, lat_if, rd_if);
      if_req = 1'b0;
      if (do_d) begin
        @(posedge clk); #1;
        serve(2, da, dwe, dwd, dty, lat_d, rd_d);
        d_req = 1'b0;
      end
    end
    idle_cycle();
  endtask

  initial begin
    #1;
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycle();

    // Fetch 0x40, memory acks in the 4th m_req cycle.
    run_txn(1, 32'h40, 0, 0, 0, 0, 0, 3, 32'h0051_0513, 0, 0);
    // Contention: fetch 0x100 vs store 0x2000.
    run_txn(1, 32'h100, 1, 1, 32'h2000, 32'hCAFE_F00D, 3'd0, 1, 32'h0000_0297, 0, 32'hDEAD_BEEF);
    // A data access then contention again (round-robin flips here).
    run_txn(0, 0, 1, 0, 32'h2004, 0, 3'd2, 0, 0, 1, 32'h0BAD_F00D);
    run_txn(1, 32'h104, 1, 1, 32'h2008, 32'h1357_9BDF, 3'd1, 0, 32'h0041_0113, 2, 0);
    // Load 0x3000 that the memory never acks: watchdog abort.
    run_txn(0, 0, 1, 0, 32'h3000, 0, 3'd0, 0, 0, 1000, 32'h5555_5555);
    // m_ack in exactly the TIMEOUT cycle wins over the abort.
    run_txn(0, 0, 1, 0, 32'h3004, 0, 3'd0, 0, 0, TO - 1, 32'h1234);
    run_txn(1, 32'h200, 0, 0, 0, 0, 0, TO - 1, 32'hA5A5_0001, 0, 0);
    run_txn(1, 32'h204, 0, 0, 0, 0, 0, TO, 32'hA5A5_0002, 0, 0);

    // Reset while BUSY_D: asynchronous return, no d_ack afterwards.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    @(posedge clk); #1;
    lg = 2;
    check("rst_pre_mreq", m_req, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    exp_if_rdata = '0; exp_d_rdata = '0; exp_sticky = 1'b0; lg = 1;
    d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle();
    run_txn(1, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0000_0013, 0, 0);

    // Back-to-back fetches 0x0, 0x4, 0x8 with a zero-wait memory.
    if_req = 1'b1; if_addr = 32'h0;
    @(posedge clk); #1;
    serve(1, 32'h0, 1'b0, 32'd0, 3'd0, 0, 32'h1111_0000);
    for (int i = 1; i < 3; i++) begin
      if_addr = 32'(4 * i);
      @(posedge clk); #1;
      check("b2b_gap_mreq", m_req, 0);
      check("b2b_gap_ack", if_ack, 0);
      check("b2b_gap_stall", stall, 1);
      @(posedge clk); #1;
      serve(1, 32'(4 * i), 1'b0, 32'd0, 3'd0, 0, 32'h1111_0000 + 32'(i));
    end
    if_req = 1'b0;
    idle_cycle();

    // Randomised mix of fetch, load, store and contention with varied latency.
    for (int n = 0; n < 200; n++) begin
      int kind, lat_i, lat_d;
      kind  = $urandom_range(0, 2);
      lat_i = ($urandom_range(0, 9) < 6) ? $urandom_range(0, 3) : $urandom_range(TO - 2, TO + 3);
      lat_d = ($urandom_range(0, 9) < 6) ? $urandom_range(0, 3) : $urandom_range(TO - 2, TO + 3);
      run_txn(kind != 1, $urandom(), kind != 0, 1'($urandom_range(0, 1)), $urandom(),
              $urandom(), 3'($urandom_range(0, 7)), lat_i, $urandom(), lat_d, $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-port unified memory between the pipeline CPU's instruction-fetch port and its data (load/store) port. Sits between the CPU core and the memory. Serialises accesses through a req/ack handshake and drives a stall back to the core while either access is outstanding. Also enforces a per-access timeout watchdog.

## Interface
- TIMEOUT, 255: cycles a granted access may wait for `m_ack` before abort; legal range 1..65535.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high, `if_addr` stable, until `if_ack`.
- if_addr  input  32  fetch byte address.
- if_ack  output  1  one-cycle completion pulse for fetch.
- if_rdata  output  32  fetched word, valid while `if_ack`=1, held afterwards.
- d_req  input  1  data request; same hold rule as `if_req`.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data byte address.
- d_wdata  input  32  store data.
- d_type  input  3  DMType code, passed through unchanged.
- d_ack  output  1  one-cycle completion pulse for data.
- d_rdata  output  32  load data, valid while `d_ack`=1.
- err  output  1  ack carries timeout abort; high only together with `if_ack` or `d_ack`.
- err_sticky  output  1  set by any timeout, cleared only by reset.
- stall  output  1  combinational: `(if_req & ~if_ack) | (d_req & ~d_ack)`.
- m_req  output  1  memory request, registered.
- m_we  output  1  memory write enable, registered.
- m_addr  output  32  memory address, registered.
- m_wdata  output  32  memory write data, registered.
- m_type  output  3  memory DMType, registered.
- m_ack  input  1  memory completion; `m_rdata` valid in same cycle.
- m_rdata  input  32  memory read data.

## Operation
- States:
  - IDLE.
  - BUSY_IF: fetch owns the memory.
  - BUSY_D: data owns the memory.
- IDLE, grant selection on each edge, among requesters whose req=1 and whose ack is not high this cycle:
  - Only one candidate: that one is granted.
  - Both candidates: data wins. Round-robin under the configuration macro below.
- On grant:
  - Register `m_addr`, `m_we`, `m_wdata`, `m_type` and set `m_req`=1.
  - Fetch grants force `m_we`=0, `m_type`=0, `m_wdata`=0.
  - Clear the timeout counter; record the grantee in `last_grant`.
- In BUSY, `m_req` and all `m_*` outputs are held stable until completion.
- Completion (`m_ack`=1 sampled in BUSY):
  - `m_req`<=0 and state<=IDLE.
  - Owner's ack<=1 for one cycle.
  - Owner's rdata<=`m_rdata` for loads and fetches; `d_rdata`<=0 for stores.
  - `err`<=0.
- Timeout: the counter increments every BUSY cycle without `m_ack`. At count = TIMEOUT with `m_ack`=0:
  - Abort exactly like a completion.
  - rdata<=0, `err`<=1, `err_sticky`<=1.
  - `m_ack` arriving in the same cycle as the TIMEOUT count wins: normal completion, no error.
- `m_ack` in IDLE is ignored.
- Counter is 16 bits and saturates; it never wraps.
- The non-owner requester may raise or drop its req at any time; it is evaluated only in IDLE.

## Timing
- Reset values:
  - State IDLE, `last_grant`=fetch.
  - All acks 0, `err` 0, `err_sticky` 0, `m_req` 0.
  - All `m_*` data/address outputs 0, rdata outputs 0.
  - Counter 0.
- Reset asserted mid-access: immediate return to reset values. No ack is generated for the aborted access.
- Latency:
  - req sampled at edge N gives `m_req`=1 after edge N.
  - `m_ack` sampled at edge M gives requester ack after edge M.
  - Minimum request-to-ack is 2 cycles with a zero-wait memory (`m_ack` high in the first `m_req` cycle).
- Back-to-back: the cycle in which ack=1 is IDLE. A new grant occurs at the next edge, so the memory sees one idle cycle between accesses. A requester may present a new address with req held high in the cycle after its ack.
- `stall` deasserts in the same cycle as the relevant ack.

## Configuration
- `MEM_ARB_RR_EN` defined: when both requests contend in IDLE, grant the requester opposite to `last_grant`.
- Undefined: fixed priority, data always beats fetch.
- Single-requester behaviour is identical either way.

## Test plan
- Fetch only, addr 0x0000_0040, memory acks 3 cycles after `m_req` with 0x0051_0513:
  - `m_addr`=0x40, `m_we`=0.
  - `if_ack` 1 cycle after `m_ack`, `if_rdata`=0x0051_0513, stall high throughout until ack.
- Simultaneous fetch 0x100 and store 0x2000/0xCAFE_F00D, `d_type`=0:
  - Without the macro: data is served first (`m_we`=1, `m_wdata`=0xCAFE_F00D), fetch is granted the cycle after `d_ack`.
  - With the macro and `last_grant`=data: fetch is served first.
- Load 0x3000 with memory never acking, TIMEOUT=8:
  - `m_req` drops after 8 BUSY cycles.
  - `d_ack`=1, `err`=1, `d_rdata`=0, `err_sticky` stays 1.
- `m_ack` asserted in exactly the TIMEOUT cycle with data 0x1234:
  - Normal completion, `err`=0, `d_rdata`=0x1234.
- Reset pulled low during BUSY_D:
  - All outputs return to reset values asynchronously.
  - No `d_ack` is issued; after release, a fresh fetch completes normally.
- Back-to-back fetches 0x0, 0x4, 0x8 with zero-wait memory:
  - Each access takes 2 cycles per word plus 1 idle cycle on `m_req`.
  - Three `if_ack` pulses carry the correct data in order.
